// File: rtl/multicycle_control_if.sv
// Bus between the multicycle control unit and its datapath.
// The master modport is the control unit: it takes the opcode fields and
// the memory handshake, and it drives every datapath control and status flag.
// The slave modport is the datapath side of the same signals.
interface multicycle_control_if #(
  parameter int unsigned ALU_CTL_W = 4
);
  logic [5:0]           op;
  logic [5:0]           funct;
  logic                 mem_ready;

  logic                 pc_write;
  logic                 pc_write_cond;
  logic                 iord;
  logic                 mem_read;
  logic                 mem_write;
  logic                 ir_write;
  logic                 mem_to_reg;
  logic                 reg_dst;
  logic                 reg_write;
  logic                 alu_src_a;
  logic [1:0]           alu_src_b;
  logic [1:0]           alu_op;
  logic [1:0]           pc_source;
  logic [ALU_CTL_W-1:0] alu_ctl;

  logic [3:0]           state;
  logic                 illegal_op;
  logic                 instr_done;

  modport master (
    input  op, funct, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, alu_ctl, state, illegal_op, instr_done
  );

  modport slave (
    output op, funct, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, alu_ctl, state, illegal_op, instr_done
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: Moore FSM driving datapath controls,
// with a combinational ALU-control decoder.
// Optional feature macro: MC_IMM_ALU_EN adds the ADDI_EX/ADDI_WB states
// for op 001000; without it that opcode is reported as illegal.
// Datapath controls and instr_done are combinational from the state (plus
// mem_ready where a stall gates a strobe); illegal_op is registered.
module multicycle_control #(
  parameter int unsigned ALU_CTL_W = 4,
  parameter int unsigned WAIT_MEM  = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  multicycle_control_if.master bus
);

  localparam int unsigned STATE_W = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_IMM_ALU_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9
`ifdef MC_IMM_ALU_EN
    ,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11
`endif
  } state_e;

  state_e     state_q;
  state_e     state_d;
  logic       illegal_q;
  logic       illegal_c;
  logic       mem_ok;
  logic [3:0] alu_ctl4;

  // Memory handshake: with WAIT_MEM=0 every access completes in one cycle.
  assign mem_ok = (WAIT_MEM == 0) ? 1'b1 : bus.mem_ready;

  // State register and registered illegal-opcode flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_c;
    end
  end

  // Next-state and per-state datapath controls; anything not set stays 0.
  always_comb begin
    state_d           = S_FETCH;
    illegal_c         = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.iord          = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = 2'b00;
    bus.pc_source     = 2'b00;
    bus.instr_done    = 1'b0;

    case (state_q)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        // PC and IR update only on the cycle the fetch completes.
        bus.ir_write  = mem_ok;
        bus.pc_write  = mem_ok;
        state_d       = mem_ok ? S_DECODE : S_FETCH;
      end

      S_DECODE: begin
        bus.alu_src_b = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MC_IMM_ALU_EN
          OP_ADDI:      state_d = S_ADDI_EX;
`endif
          default: begin
            state_d   = S_FETCH;
            illegal_c = 1'b1;
          end
        endcase
      end

      S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        if (bus.op == OP_LW) begin
          state_d = S_MEM_RD;
        end else if (bus.op == OP_SW) begin
          state_d = S_MEM_WR;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
        state_d      = mem_ok ? S_MEM_WB : S_MEM_RD;
      end

      S_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end

      S_MEM_WR: begin
        bus.mem_write  = 1'b1;
        bus.iord       = 1'b1;
        bus.instr_done = mem_ok;
        state_d        = mem_ok ? S_FETCH : S_MEM_WR;
      end

      S_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
        state_d       = S_R_WB;
      end

      S_R_WB: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end

      S_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = 2'b01;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
        bus.instr_done    = 1'b1;
        state_d           = S_FETCH;
      end

      S_JUMP: begin
        bus.pc_write   = 1'b1;
        bus.pc_source  = 2'b10;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end

`ifdef MC_IMM_ALU_EN
      S_ADDI_EX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_d       = S_ADDI_WB;
      end

      S_ADDI_WB: begin
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
`endif

      // Unused encodings recover to FETCH with all controls low.
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // ALU function decode from alu_op and, for R-type, funct.
  always_comb begin
    alu_ctl4 = 4'b1111;
    case (bus.alu_op)
      2'b00: alu_ctl4 = 4'b0010;
      2'b01: alu_ctl4 = 4'b0110;
      2'b10: begin
        case (bus.funct)
          FN_ADD:  alu_ctl4 = 4'b0010;
          FN_SUB:  alu_ctl4 = 4'b0110;
          FN_AND:  alu_ctl4 = 4'b0000;
          FN_OR:   alu_ctl4 = 4'b0001;
          FN_SLT:  alu_ctl4 = 4'b0111;
          default: alu_ctl4 = 4'b1111;
        endcase
      end
      default: alu_ctl4 = 4'b1111;
    endcase
  end

  assign bus.alu_ctl    = ALU_CTL_W'(alu_ctl4);
  assign bus.state      = state_q;
  assign bus.illegal_op = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class
// through its state sequence and checks state, packed controls, alu_ctl,
// instr_done and illegal_op against hand-derived constants.
module tb_multicycle_control;

  // Packed control vector order:
  // {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
  //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source}
  localparam logic [15:0] C_FETCH_RDY = 16'h9410;
  localparam logic [15:0] C_FETCH_STL = 16'h1010;
  localparam logic [15:0] C_DECODE    = 16'h0030;
  localparam logic [15:0] C_MEM_ADDR  = 16'h0060;
  localparam logic [15:0] C_MEM_RD    = 16'h3000;
  localparam logic [15:0] C_MEM_WB    = 16'h0280;
  localparam logic [15:0] C_MEM_WR    = 16'h2800;
  localparam logic [15:0] C_EXEC      = 16'h0048;
  localparam logic [15:0] C_R_WB      = 16'h0180;
  localparam logic [15:0] C_BRANCH    = 16'h4045;
  localparam logic [15:0] C_JUMP      = 16'h8002;
`ifdef MC_IMM_ALU_EN
  localparam logic [15:0] C_ADDI_EX   = 16'h0060;
  localparam logic [15:0] C_ADDI_WB   = 16'h0080;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] ctrl;
  int          checks;
  int          errors;

  multicycle_control_if #(.ALU_CTL_W(4)) bus ();

  multicycle_control #(.ALU_CTL_W(4), .WAIT_MEM(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign ctrl = {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read,
                 bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                 bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                 bus.pc_source};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [3:0] st, input logic [15:0] c,
                        input logic done);
    chk({tag, ".state"}, 32'(bus.state), 32'(st));
    chk({tag, ".ctrl"}, 32'(ctrl), 32'(c));
    chk({tag, ".done"}, 32'(bus.instr_done), 32'(done));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] fn_tab [6];
    logic [3:0] ctl_tab [6];
    fn_tab  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h3f};
    ctl_tab = '{4'h2,  4'h6,  4'h0,  4'h1,  4'h7,  4'hf};
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.op = 6'd0;
    bus.funct = 6'd0;
    bus.mem_ready = 1'b0;

    // Reset state
    #12;
    chk_st("reset", 4'd0, C_FETCH_STL, 1'b0);
    chk("reset.illegal", 32'(bus.illegal_op), 32'd0);
    rst_n = 1'b1;

    // R-type sub: 0,1,6,7,0
    bus.op = 6'b000000; bus.funct = 6'b100010; bus.mem_ready = 1'b1;
    #1;
    chk_st("r.fetch", 4'd0, C_FETCH_RDY, 1'b0);
    tick;
    chk_st("r.decode", 4'd1, C_DECODE, 1'b0);
    chk("r.decode.alu", 32'(bus.alu_ctl), 32'h2);
    tick;
    chk_st("r.exec", 4'd6, C_EXEC, 1'b0);
    chk("r.exec.alu_sub", 32'(bus.alu_ctl), 32'h6);
    for (int i = 0; i < 6; i++) begin
      bus.funct = fn_tab[i];
      #1;
      chk($sformatf("alu.funct%0h", fn_tab[i]), 32'(bus.alu_ctl), 32'(ctl_tab[i]));
    end
    bus.funct = 6'b100010;
    tick;
    chk_st("r.wb", 4'd7, C_R_WB, 1'b1);
    tick;
    chk_st("r.back", 4'd0, C_FETCH_RDY, 1'b0);

    // lw with fetch stall and 3-cycle MEM_RD stall
    bus.op = 6'b100011; bus.mem_ready = 1'b0;
    #1;
    chk_st("lw.fstall", 4'd0, C_FETCH_STL, 1'b0);
    tick;
    chk_st("lw.fstall2", 4'd0, C_FETCH_STL, 1'b0);
    bus.mem_ready = 1'b1;
    #1;
    chk("lw.fetch.ctrl", 32'(ctrl), 32'(C_FETCH_RDY));
    tick;
    chk_st("lw.decode", 4'd1, C_DECODE, 1'b0);
    tick;
    chk_st("lw.addr", 4'd2, C_MEM_ADDR, 1'b0);
    bus.mem_ready = 1'b0;
    tick;
    chk_st("lw.rd1", 4'd3, C_MEM_RD, 1'b0);
    tick;
    chk_st("lw.rd2", 4'd3, C_MEM_RD, 1'b0);
    tick;
    chk_st("lw.rd3", 4'd3, C_MEM_RD, 1'b0);
    bus.mem_ready = 1'b1;
    #1;
    chk_st("lw.rd4", 4'd3, C_MEM_RD, 1'b0);
    tick;
    chk_st("lw.wb", 4'd4, C_MEM_WB, 1'b1);
    tick;
    chk_st("lw.back", 4'd0, C_FETCH_RDY, 1'b0);

    // sw: 0,1,2,5,0 with one MEM_WR stall cycle
    bus.op = 6'b101011;
    tick;
    chk_st("sw.decode", 4'd1, C_DECODE, 1'b0);
    tick;
    chk_st("sw.addr", 4'd2, C_MEM_ADDR, 1'b0);
    bus.mem_ready = 1'b0;
    tick;
    chk_st("sw.wr_stall", 4'd5, C_MEM_WR, 1'b0);
    bus.mem_ready = 1'b1;
    #1;
    chk_st("sw.wr", 4'd5, C_MEM_WR, 1'b1);
    tick;
    chk_st("sw.back", 4'd0, C_FETCH_RDY, 1'b0);

    // beq
    bus.op = 6'b000100;
    tick;
    chk_st("beq.decode", 4'd1, C_DECODE, 1'b0);
    tick;
    chk_st("beq.branch", 4'd8, C_BRANCH, 1'b1);
    chk("beq.alu", 32'(bus.alu_ctl), 32'h6);
    tick;
    chk_st("beq.back", 4'd0, C_FETCH_RDY, 1'b0);

    // j
    bus.op = 6'b000010;
    tick;
    tick;
    chk_st("j.jump", 4'd9, C_JUMP, 1'b1);
    tick;
    chk_st("j.back", 4'd0, C_FETCH_RDY, 1'b0);

    // illegal opcode
    bus.op = 6'b111111;
    tick;
    chk_st("ill.decode", 4'd1, C_DECODE, 1'b0);
    chk("ill.decode.flag", 32'(bus.illegal_op), 32'd0);
    tick;
    chk_st("ill.fetch", 4'd0, C_FETCH_RDY, 1'b0);
    chk("ill.flag", 32'(bus.illegal_op), 32'd1);
    tick;
    chk("ill.flag_clear", 32'(bus.illegal_op), 32'd0);
    chk("ill.next_decode", 32'(bus.state), 32'd1);

    // addi: legal only with the immediate-ALU feature
    bus.op = 6'b001000;
    tick;
`ifdef MC_IMM_ALU_EN
    chk_st("addi.ex", 4'd10, C_ADDI_EX, 1'b0);
    chk("addi.alu", 32'(bus.alu_ctl), 32'h2);
    tick;
    chk_st("addi.wb", 4'd11, C_ADDI_WB, 1'b1);
    tick;
    chk_st("addi.back", 4'd0, C_FETCH_RDY, 1'b0);
    chk("addi.flag", 32'(bus.illegal_op), 32'd0);
`else
    chk_st("addi.ill", 4'd0, C_FETCH_RDY, 1'b0);
    chk("addi.flag", 32'(bus.illegal_op), 32'd1);
`endif
    tick;
    chk("addi.redecode", 32'(bus.state), 32'd1);

    // Reset mid MEM_RD, between edges
    bus.op = 6'b100011;
    tick;
    chk("rst.addr", 32'(bus.state), 32'd2);
    bus.mem_ready = 1'b0;
    tick;
    chk("rst.rd", 32'(bus.state), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk_st("rst.async", 4'd0, C_FETCH_STL, 1'b0);
    chk("rst.illegal", 32'(bus.illegal_op), 32'd0);
    #1 rst_n = 1'b1;
    bus.op = 6'b000000; bus.funct = 6'b100000; bus.mem_ready = 1'b1;
    #1;
    chk_st("rst.fetch", 4'd0, C_FETCH_RDY, 1'b0);
    tick;
    chk_st("rst.decode", 4'd1, C_DECODE, 1'b0);
    tick;
    chk("rst.exec.alu_add", 32'(bus.alu_ctl), 32'h2);
    tick;
    chk_st("rst.wb", 4'd7, C_R_WB, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
